pc_unit: RTL and testbench

Parametrised program-counter unit for the multi-cycle-free MIPS CPU. It succeeds the plain PC latch with the following additions:
- on-chip next-PC selection;
- stall;
- halt/resume;
- exception entry/return backed by a nested EPC stack.

It sits at the head of fetch, drives the instruction-memory address, and takes redirect requests from decode/execute.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pc_unit_if.sv | 38 +++
 rtl/epc_stack.sv | 48 ++++
 rtl/pc_unit.sv | 124 ++++++++++++
 tb/tb_pc_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address defaults, PC-unit state encoding and the
// next-PC select encoding also used by the control unit.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0040_0004;
    localparam int unsigned DEF_STEP      = 4;

    typedef enum logic {
        RUN,
        HALT
    } pc_state_t;

    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_SEQ,
        NPC_BR,
        NPC_JMP,
        NPC_ERET,
        NPC_EXC
    } npc_sel_t;

endpackage

// File: rtl/pc_unit_if.sv
// Redirect/control requests into the PC unit and its observable state.
interface pc_unit_if #(
    parameter int unsigned ADDR_W    = cpu_pkg::DEF_ADDR_W,
    parameter int unsigned EPC_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(EPC_DEPTH) + 1;

    logic              stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              jmp;
    logic [ADDR_W-1:0] jmp_target;
    logic              exc_req;
    logic              eret;
    logic              halt;
    logic              resume;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next_seq;
    logic [ADDR_W-1:0] epc_top;
    logic [LVL_W-1:0]  epc_level;
    logic              halted;
    logic              exc_ovf;
    logic              eret_err;

    modport master (
        output stall, br_taken, br_target, jmp, jmp_target,
               exc_req, eret, halt, resume,
        input  pc, pc_next_seq, epc_top, epc_level, halted, exc_ovf, eret_err
    );

    modport slave (
        input  stall, br_taken, br_target, jmp, jmp_target,
               exc_req, eret, halt, resume,
        output pc, pc_next_seq, epc_top, epc_level, halted, exc_ovf, eret_err
    );

endinterface

// File: rtl/epc_stack.sv
// Exception-PC LIFO: push when full overwrites the top entry; pop when empty
// is ignored. State updates on the falling clock edge like the rest of fetch.
module epc_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LVL_W-1:0] cnt;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;

    assign full    = (cnt == LVL_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign top_idx = PTR_W'(cnt - 1'b1);
    assign wr_idx  = full ? top_idx : cnt[PTR_W-1:0];
    assign top     = empty ? '0 : mem[top_idx];
    assign level   = cnt;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_idx] <= din;
            if (!full) begin
                cnt <= cnt + 1'b1;
            end
        end else if (pop && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, stall, halt/resume and exception
// entry/return through a nested EPC stack. All state changes on falling edges.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter int unsigned       STEP      = DEF_STEP,
    parameter int unsigned       EPC_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_unit_if.slave bus
);
    localparam int unsigned LVL_W = $clog2(EPC_DEPTH) + 1;

    pc_state_t         state;
    pc_state_t         state_next;
    npc_sel_t          sel;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] epc_top;
    logic [LVL_W-1:0]  epc_level;
    logic              push;
    logic              pop;
    logic              stk_full;
    logic              stk_empty;
    logic              ovf_q;
    logic              err_q;
    logic              set_ovf;
    logic              set_err;

    assign pc_seq = pc_q + ADDR_W'(STEP);

    epc_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (EPC_DEPTH)
    ) u_epc (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_q),
        .top   (epc_top),
        .level (epc_level),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Stall leaves every default in place, so nothing below can move.
    always_comb begin
        state_next = state;
        sel        = NPC_HOLD;
        push       = 1'b0;
        pop        = 1'b0;
        set_ovf    = 1'b0;
        set_err    = 1'b0;
        if (!bus.stall) begin
            if (bus.exc_req) begin
                // Exception also wakes a halted core; from RUN a same-edge halt still wins.
                sel        = NPC_EXC;
                push       = 1'b1;
                set_ovf    = stk_full;
                state_next = (state == RUN && bus.halt) ? HALT : RUN;
            end else if (state == HALT) begin
                if (bus.resume) begin
                    state_next = RUN;
                end
            end else begin
                if (bus.eret) begin
                    sel     = NPC_ERET;
                    pop     = 1'b1;
                    set_err = stk_empty;
                end else if (bus.jmp) begin
                    sel = NPC_JMP;
                end else if (bus.br_taken) begin
                    sel = NPC_BR;
                end else begin
                    sel = NPC_SEQ;
                end
                if (bus.halt) begin
                    state_next = HALT;
                end
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (sel)
            NPC_SEQ:  pc_d = pc_seq;
            NPC_BR:   pc_d = bus.br_target;
            NPC_JMP:  pc_d = bus.jmp_target;
            NPC_ERET: pc_d = stk_empty ? EXC_VEC : epc_top;
            NPC_EXC:  pc_d = EXC_VEC;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            pc_q  <= pc_d;
            ovf_q <= ovf_q | set_ovf;
            err_q <= err_q | set_err;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_next_seq = pc_seq;
    assign bus.epc_top     = epc_top;
    assign bus.epc_level   = epc_level;
    assign bus.halted      = (state == HALT);
    assign bus.exc_ovf     = ovf_q;
    assign bus.eret_err    = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// against a queue-based reference model of the PC and EPC stack.
module tb_pc_unit;

    localparam logic [31:0] RST_V = 32'h0040_0000;
    localparam logic [31:0] EXC_V = 32'h0040_0004;
    localparam int          DEPTH = 4;

    logic clk = 1'b1;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_ovf;
    bit          m_err;
    logic [31:0] m_stk[$];

    always #5 clk = ~clk;

    pc_unit_if #(.ADDR_W(32), .EPC_DEPTH(DEPTH)) bus ();

    pc_unit #(
        .ADDR_W    (32),
        .RESET_VEC (RST_V),
        .EXC_VEC   (EXC_V),
        .STEP      (4),
        .EPC_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic clear_inputs();
        bus.stall = 0; bus.br_taken = 0; bus.br_target = '0;
        bus.jmp = 0; bus.jmp_target = '0; bus.exc_req = 0;
        bus.eret = 0; bus.halt = 0; bus.resume = 0;
    endtask

    task automatic model_reset();
        m_pc = RST_V; m_halt = 0; m_ovf = 0; m_err = 0;
        m_stk.delete();
    endtask

    // Model of one falling edge, written from the request rules directly.
    task automatic model_step();
        if (bus.stall) return;
        if (bus.exc_req) begin
            if (m_stk.size() == DEPTH) begin
                m_stk[m_stk.size()-1] = m_pc;
                m_ovf = 1;
            end else begin
                m_stk.push_back(m_pc);
            end
            m_pc   = EXC_V;
            m_halt = !m_halt && bus.halt;
        end else if (m_halt) begin
            if (bus.resume) m_halt = 0;
        end else begin
            if (bus.eret) begin
                if (m_stk.size() == 0) begin
                    m_pc = EXC_V; m_err = 1;
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end else if (bus.jmp)      m_pc = bus.jmp_target;
            else if (bus.br_taken)     m_pc = bus.br_target;
            else                       m_pc = m_pc + 32'd4;
            if (bus.halt) m_halt = 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        #2;
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1;
        model_reset();
        repeat (5) tick();
        #3;
        rst_n = 0;
        model_reset();
        #1;
        checks++; if (bus.pc !== RST_V) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc, RST_V); end
        checks++; if (bus.epc_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.epc_level); end
        checks++; if (bus.epc_top !== 32'h0) begin errors++; $display("FAIL reset_top: got %h expected 0", bus.epc_top); end
        checks++; if ({bus.halted, bus.exc_ovf, bus.eret_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.halted, bus.exc_ovf, bus.eret_err}); end
        #1;
        rst_n = 1;
        repeat (3) tick();
        checks++; if (bus.pc !== 32'h0040_000C) begin errors++; $display("FAIL reset_release_pc: got %h expected 0040000c", bus.pc); end
    endtask

    task automatic test_priority();
        do_reset();
        repeat (4) tick();
        checks++; if (bus.pc !== 32'h0040_0010) begin errors++; $display("FAIL prio_start_pc: got %h expected 00400010", bus.pc); end
        bus.jmp = 1; bus.jmp_target = 32'h0040_0100;
        bus.br_taken = 1; bus.br_target = 32'h0040_0200;
        tick();
        checks++; if (bus.pc !== 32'h0040_0100) begin errors++; $display("FAIL prio_jmp_over_br: got %h expected 00400100", bus.pc); end
        bus.br_taken = 0; bus.jmp_target = 32'h0040_0010;
        tick();
        bus.jmp_target = 32'h0040_0100; bus.br_taken = 1; bus.exc_req = 1;
        tick();
        checks++; if (bus.pc !== EXC_V) begin errors++; $display("FAIL prio_exc_pc: got %h expected %h", bus.pc, EXC_V); end
        checks++; if (bus.epc_top !== 32'h0040_0010) begin errors++; $display("FAIL prio_exc_epc: got %h expected 00400010", bus.epc_top); end
        checks++; if (bus.epc_level !== 3'd1) begin errors++; $display("FAIL prio_exc_level: got %0d expected 1", bus.epc_level); end
        clear_inputs();
        bus.eret = 1;
        tick();
        checks++; if (bus.pc !== 32'h0040_0010 || bus.epc_level !== 3'd0) begin errors++; $display("FAIL prio_eret: got pc %h level %0d expected 00400010 level 0", bus.pc, bus.epc_level); end
        clear_inputs();
    endtask

    task automatic test_nesting();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            a = 32'h0040_1000 + 32'(i) * 32'h100;
            clear_inputs(); bus.jmp = 1; bus.jmp_target = a; tick();
            clear_inputs(); bus.exc_req = 1; tick();
            checks++; if (bus.epc_level !== 3'(i + 1) || bus.epc_top !== a) begin errors++; $display("FAIL nest_push%0d: got level %0d top %h expected %0d %h", i, bus.epc_level, bus.epc_top, i + 1, a); end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            a = 32'h0040_1000 + 32'(i) * 32'h100;
            clear_inputs(); bus.eret = 1; tick();
            checks++; if (bus.pc !== a || bus.epc_level !== 3'(i)) begin errors++; $display("FAIL nest_pop%0d: got pc %h level %0d expected %h %0d", i, bus.pc, bus.epc_level, a, i); end
        end
        for (int i = 0; i <= DEPTH; i++) begin
            a = 32'h0040_2000 + 32'(i) * 32'h10;
            clear_inputs(); bus.jmp = 1; bus.jmp_target = a; tick();
            if (i == DEPTH) begin
                checks++; if (bus.exc_ovf !== 1'b0) begin errors++; $display("FAIL nest_ovf_early: got %b expected 0", bus.exc_ovf); end
            end
            clear_inputs(); bus.exc_req = 1; tick();
        end
        a = 32'h0040_2000 + 32'(DEPTH) * 32'h10;
        checks++; if (bus.exc_ovf !== 1'b1 || bus.epc_level !== 3'(DEPTH) || bus.epc_top !== a) begin errors++; $display("FAIL nest_overflow: got ovf %b level %0d top %h expected 1 %0d %h", bus.exc_ovf, bus.epc_level, bus.epc_top, DEPTH, a); end
        clear_inputs();
    endtask

    task automatic test_empty_eret();
        do_reset();
        tick();
        bus.eret = 1; bus.jmp = 1; bus.jmp_target = 32'h0040_0300;
        tick();
        checks++; if (bus.pc !== EXC_V || bus.eret_err !== 1'b1 || bus.epc_level !== 3'd0) begin errors++; $display("FAIL empty_eret: got pc %h err %b level %0d expected %h 1 0", bus.pc, bus.eret_err, bus.epc_level, EXC_V); end
        clear_inputs();
        tick();
        checks++; if (bus.eret_err !== 1'b1) begin errors++; $display("FAIL eret_err_sticky: got %b expected 1", bus.eret_err); end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (2) tick();
        bus.stall = 1; bus.jmp = 1; bus.jmp_target = 32'h0040_0800; bus.exc_req = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc !== 32'h0040_0008 || bus.epc_level !== 3'd0) begin errors++; $display("FAIL stall_hold%0d: got pc %h level %0d expected 00400008 0", i, bus.pc, bus.epc_level); end
        end
        bus.stall = 0;
        tick();
        checks++; if (bus.pc !== EXC_V || bus.epc_level !== 3'd1 || bus.epc_top !== 32'h0040_0008) begin errors++; $display("FAIL stall_release_exc: got pc %h level %0d top %h expected %h 1 00400008", bus.pc, bus.epc_level, bus.epc_top, EXC_V); end
        clear_inputs();
    endtask

    task automatic test_halt_wrap();
        do_reset();
        tick();
        bus.halt = 1;
        tick();
        checks++; if (bus.halted !== 1'b1 || bus.pc !== 32'h0040_0008) begin errors++; $display("FAIL halt_enter: got halted %b pc %h expected 1 00400008", bus.halted, bus.pc); end
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            bus.jmp = 1; bus.jmp_target = $urandom;
            tick();
            checks++; if (bus.pc !== 32'h0040_0008 || bus.halted !== 1'b1) begin errors++; $display("FAIL halt_frozen%0d: got pc %h halted %b expected 00400008 1", i, bus.pc, bus.halted); end
        end
        clear_inputs(); bus.resume = 1;
        tick();
        checks++; if (bus.halted !== 1'b0 || bus.pc !== m_pc) begin errors++; $display("FAIL resume: got halted %b pc %h expected 0 %h", bus.halted, bus.pc, m_pc); end
        clear_inputs();
        tick();
        checks++; if (bus.pc !== 32'h0040_000C) begin errors++; $display("FAIL resume_inc: got %h expected 0040000c", bus.pc); end
        bus.jmp = 1; bus.jmp_target = 32'hFFFF_FFFC;
        tick();
        checks++; if (bus.pc !== 32'hFFFF_FFFC || bus.pc_next_seq !== 32'h0) begin errors++; $display("FAIL wrap_target: got pc %h seq %h expected fffffffc 00000000", bus.pc, bus.pc_next_seq); end
        clear_inputs();
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 00000000", bus.pc); end
        bus.halt = 1; tick();
        clear_inputs(); bus.exc_req = 1; tick();
        checks++; if (bus.halted !== 1'b0 || bus.pc !== EXC_V || bus.epc_top !== 32'h4) begin errors++; $display("FAIL exc_in_halt: got halted %b pc %h top %h expected 0 %h 00000004", bus.halted, bus.pc, bus.epc_top, EXC_V); end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [31:0] exp_top;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.stall      = ($urandom_range(99) < 10);
            bus.exc_req    = ($urandom_range(99) < 8);
            bus.eret       = ($urandom_range(99) < 12);
            bus.jmp        = ($urandom_range(99) < 15);
            bus.br_taken   = ($urandom_range(99) < 20);
            bus.halt       = ($urandom_range(99) < 5);
            bus.resume     = ($urandom_range(99) < 30);
            bus.jmp_target = $urandom;
            bus.br_target  = $urandom;
            tick();
            exp_top = (m_stk.size() == 0) ? 32'h0 : m_stk[m_stk.size()-1];
            checks++;
            if (bus.pc !== m_pc || bus.pc_next_seq !== m_pc + 32'd4 || bus.epc_top !== exp_top ||
                bus.epc_level !== 3'(m_stk.size()) || bus.halted !== m_halt ||
                bus.exc_ovf !== m_ovf || bus.eret_err !== m_err) begin
                errors++;
                $display("FAIL random%0d: got pc %h seq %h top %h lvl %0d h %b o %b e %b expected %h %h %h %0d %b %b %b",
                         n, bus.pc, bus.pc_next_seq, bus.epc_top, bus.epc_level, bus.halted, bus.exc_ovf, bus.eret_err,
                         m_pc, m_pc + 32'd4, exp_top, m_stk.size(), m_halt, m_ovf, m_err);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_priority();
        test_nesting();
        test_empty_eret();
        test_stall();
        test_halt_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
